// File: rtl/sync_fifo_prog.sv
// ============================================================================
// Module   : sync_fifo_prog
// Brief    : Single-clock FIFO with programmable almost-full/almost-empty
//            levels, occupancy count, optional FWFT, flush and sticky errors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_prog #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter bit FWFT  = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     wrt_enable,
    input  logic                     red_enable,
    input  logic [$clog2(DEPTH):0]   af_level,
    input  logic [$clog2(DEPTH):0]   ae_level,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    output logic                     full,
    output logic                     empty,
    output logic                     alm_full,
    output logic                     alm_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_PW    = c_AW + 1;
    localparam logic [c_PW-1:0] c_DEPTH = c_PW'(DEPTH);
    localparam logic [c_PW-1:0] c_ONE   = c_PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_PW-1:0]  wptr_q, wptr_d;
    logic [c_PW-1:0]  rptr_q, rptr_d;
    logic [WIDTH-1:0] rdata_q;
    logic             overflow_q, underflow_q;

    logic [c_PW-1:0]  w_count;
    logic             w_full, w_empty, w_wr_ok, w_rd_ok, w_clr;

    // Pointers carry an extra wrap bit so full and empty stay distinct.
    assign w_count = wptr_q - rptr_q;
    assign w_full  = (w_count == c_DEPTH);
    assign w_empty = (w_count == '0);
    assign w_wr_ok = wrt_enable && !w_full;
    assign w_rd_ok = red_enable && !w_empty;
    assign w_clr   = reset || flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (w_wr_ok) wptr_d = wptr_q + c_ONE;
        if (w_rd_ok) rptr_d = rptr_q + c_ONE;
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (wrt_enable && w_full)  overflow_q  <= 1'b1;
            if (red_enable && w_empty) underflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok && !w_clr) mem_q[wptr_q[c_AW-1:0]] <= wdata;
    end

    generate
        if (FWFT) begin : g_fwft
            logic [c_PW-1:0] w_rptr_nxt;
            assign w_rptr_nxt = rptr_q + c_ONE;

            // Output register always holds the head word; a write landing in an
            // empty FIFO, or behind a last-word pop, bypasses the memory.
            always_ff @(posedge clk) begin
                if (w_clr) begin
                    rdata_q <= '0;
                end else if (w_wr_ok && w_empty) begin
                    rdata_q <= wdata;
                end else if (w_rd_ok) begin
                    if (w_count == c_ONE) begin
                        if (w_wr_ok) rdata_q <= wdata;
                    end else begin
                        rdata_q <= mem_q[w_rptr_nxt[c_AW-1:0]];
                    end
                end
            end

            assign rvalid = !w_empty;
        end else begin : g_std
            logic rvalid_q;

            always_ff @(posedge clk) begin
                if (w_clr) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= w_rd_ok;
                    if (w_rd_ok) rdata_q <= mem_q[rptr_q[c_AW-1:0]];
                end
            end

            assign rvalid = rvalid_q;
        end
    endgenerate

    assign rdata     = rdata_q;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = w_count;
    assign alm_full  = (w_count >= af_level);
    assign alm_empty = (w_count <= ae_level);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

`default_nettype wire
